// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the slave and master ends of the link.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_t;

    localparam int SPI_WIDTH = 32;
    localparam bit CPOL      = 1'b0;
    localparam bit CPHA      = 1'b0;
endpackage

// File: rtl/spi_sck_gen.sv
// Half-period divider: tc pulses on the last clk of every CLK_DIV-cycle half-period while enabled.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tc
);
    localparam int DW = $clog2(CLK_DIV) + 1;

    logic [DW-1:0] div;

    assign tc = en && (div == DW'(CLK_DIV - 1));

    // Held at zero while disabled so every transfer starts on a full half-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div <= '0;
        else if (!en || tc)
            div <= '0;
        else
            div <= div + 1'b1;
    end
endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first SPI master: one WIDTH-bit full-duplex word per start/done handshake.
module spi_master
    import spi_pkg::*;
#(
    parameter int WIDTH   = SPI_WIDTH,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done,
    output logic             sck,
    output logic             sdo,
    input  logic             sdi,
    output logic             cs_n
);
    localparam int BW = $clog2(WIDTH) + 1;

    spi_state_t       state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bitcnt;
    logic             tc;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk   (clk),
        .reset (reset),
        .en    (state != IDLE),
        .tc    (tc)
    );

    // One register serves both directions: the MSB drives sdo, sdi enters at the LSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sck     <= CPOL;
            sdo     <= 1'b0;
            cs_n    <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg  <= tx_data;
                        sdo    <= tx_data[WIDTH-1];
                        cs_n   <= 1'b0;
                        busy   <= 1'b1;
                        bitcnt <= '0;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (tc) begin
                        sck   <= 1'b1;
                        shreg <= {shreg[WIDTH-2:0], sdi};
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (tc) begin
                        if (sck) begin
                            sck    <= 1'b0;
                            bitcnt <= bitcnt + 1'b1;
                            // Last falling edge: leave sdo on the final bit through HOLD.
                            if (bitcnt == BW'(WIDTH - 1))
                                state <= HOLD;
                            else
                                sdo <= shreg[WIDTH-1];
                        end else begin
                            sck   <= 1'b1;
                            shreg <= {shreg[WIDTH-2:0], sdi};
                        end
                    end
                end
                HOLD: begin
                    if (tc) begin
                        cs_n    <= 1'b1;
                        rx_data <= shreg;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        sdo     <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
